// File: rtl/data_sram_resp_pkg.sv
// Shared widths, lane count and read-latency bounds for the data SRAM response block.
package data_sram_resp_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned NumLanes     = 4;
  localparam int unsigned RdLatencyMin = 1;
  localparam int unsigned RdLatencyMax = 4;

  typedef logic [DataWidth-1:0] word_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rd_delay_pipe.sv
// Valid/data/error shift pipe that delays array read responses by DEPTH cycles.
module rd_delay_pipe
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  in_valid,
  input  word_t in_data,
  input  logic  in_err,
  output logic  out_valid,
  output word_t out_data,
  output logic  out_err
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;
  word_t            data_q [DEPTH];

  // Data and error only advance alongside a valid beat, so the last stage holds between responses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
        err_q[0]  <= in_err;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];

endmodule

// File: rtl/data_sram_resp.sv
// Word-addressed data SRAM with byte strobes, fixed read latency, range checking and
// saturating access counters. Never back-pressures the requester.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter int unsigned          RD_LATENCY  = 1,
  parameter logic [AddrWidth-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 data_sram_en,
  input  logic [NumLanes-1:0]  data_sram_we,
  input  logic [AddrWidth-1:0] data_sram_addr,
  input  word_t                data_sram_wdata,
  output word_t                data_sram_rdata,
  output logic                 rdata_valid,
  output logic                 addr_err,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  localparam int unsigned IdxWidth = $clog2(DEPTH_WORDS);
  // Out-of-bounds latency settings are clamped to the supported range.
  localparam int unsigned Latency  = (RD_LATENCY < RdLatencyMin) ? RdLatencyMin :
                                     (RD_LATENCY > RdLatencyMax) ? RdLatencyMax : RD_LATENCY;

  logic [AddrWidth-1:0] offset;
  logic                 in_range;
  logic [IdxWidth-1:0]  idx;
  logic                 req_rd;
  logic                 req_wr;
  logic                 wr_acc;

  assign offset   = data_sram_addr - BASE_ADDR;
  assign in_range = (offset >> (IdxWidth + 2)) == '0;
  assign idx      = offset[IdxWidth+1:2];
  assign req_rd   = data_sram_en && (data_sram_we == '0);
  assign req_wr   = data_sram_en && (data_sram_we != '0);
  assign wr_acc   = resetn && req_wr && in_range;

  word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < NumLanes; i++) begin
        if (data_sram_we[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  logic        s0_valid_q;
  logic        s0_err_q;
  word_t       s0_data_q;
  logic        addr_err_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Array read stage: first cycle of read latency, plus range error and counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_data_q  <= '0;
      addr_err_q <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      s0_valid_q <= req_rd;
      addr_err_q <= data_sram_en && !in_range;
      if (req_rd) begin
        s0_data_q <= mem[idx];
        s0_err_q  <= !in_range;
      end
      if (req_rd && in_range) begin
        rd_cnt_q <= sat_inc(rd_cnt_q);
      end
      if (req_wr && in_range) begin
        wr_cnt_q <= sat_inc(wr_cnt_q);
      end
    end
  end

  logic  out_valid;
  logic  out_err;
  word_t out_data;

  if (Latency == 1) begin : g_no_pipe
    assign out_valid = s0_valid_q;
    assign out_data  = s0_data_q;
    assign out_err   = s0_err_q;
  end else begin : g_pipe
    rd_delay_pipe #(
      .DEPTH(Latency - 1)
    ) u_rd_delay_pipe (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (s0_valid_q),
      .in_data  (s0_data_q),
      .in_err   (s0_err_q),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_err  (out_err)
    );
  end

  // Out-of-range reads return zero; the error bit held with the data keeps the hold behaviour.
  assign data_sram_rdata = out_err ? '0 : out_data;
  assign rdata_valid     = out_valid;
  assign addr_err        = addr_err_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: four instances (latencies 1,3,4,2; two base addresses) against a
// behavioural model of memory contents and arrival-time-indexed responses.
module tb_data_sram_resp;

  localparam int NDut  = 4;
  localparam int Words = 16;
  localparam int unsigned Lat [NDut] = '{1, 3, 4, 2};
  localparam logic [31:0] Base [NDut] = '{32'h0, 32'h0, 32'h0, 32'h100};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] rdata [NDut];
  logic [31:0] rd_cnt [NDut];
  logic [31:0] wr_cnt [NDut];
  logic        rdata_valid [NDut];
  logic        addr_err [NDut];

  always #5 clk = ~clk;

  data_sram_resp #(.DEPTH_WORDS(Words), .RD_LATENCY(1), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .resetn(resetn), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .addr_err(addr_err[0]),
    .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));
  data_sram_resp #(.DEPTH_WORDS(Words), .RD_LATENCY(3), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .resetn(resetn), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .addr_err(addr_err[1]),
    .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));
  data_sram_resp #(.DEPTH_WORDS(Words), .RD_LATENCY(4), .BASE_ADDR(32'h0)) u_dut2 (
    .clk(clk), .resetn(resetn), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(rdata[2]), .rdata_valid(rdata_valid[2]), .addr_err(addr_err[2]),
    .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2]));
  data_sram_resp #(.DEPTH_WORDS(Words), .RD_LATENCY(2), .BASE_ADDR(32'h100)) u_dut3 (
    .clk(clk), .resetn(resetn), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(rdata[3]), .rdata_valid(rdata_valid[3]), .addr_err(addr_err[3]),
    .rd_cnt(rd_cnt[3]), .wr_cnt(wr_cnt[3]));

  // Reference model: word contents per instance, and responses keyed by the edge they appear after.
  logic [31:0] mem_m  [NDut][Words];
  logic        ring_v [NDut][8];
  logic [31:0] ring_d [NDut][8];
  logic        exp_v   [NDut];
  logic        exp_err [NDut];
  logic [31:0] exp_d   [NDut];
  logic [31:0] exp_rc  [NDut];
  logic [31:0] exp_wc  [NDut];
  int unsigned edge_k = 0;
  int          total = 0;
  int          bad = 0;

  task automatic cycle(input logic rst, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off;
    logic        inr;
    int unsigned idx;
    int unsigned slot;
    resetn          = rst;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    @(posedge clk);
    for (int j = 0; j < NDut; j++) begin
      if (!rst) begin
        for (int s = 0; s < 8; s++) ring_v[j][s] = 1'b0;
        exp_v[j] = 1'b0; exp_d[j] = 32'h0; exp_err[j] = 1'b0;
        exp_rc[j] = 32'h0; exp_wc[j] = 32'h0;
      end else begin
        off = addr - Base[j];
        inr = off < 32'(Words * 4);
        idx = 32'(off[5:2]);
        exp_err[j] = en && !inr;
        if (en && we == 4'h0) begin
          slot = (edge_k + Lat[j] - 1) % 8;
          ring_v[j][slot] = 1'b1;
          ring_d[j][slot] = inr ? mem_m[j][idx] : 32'h0;
          if (inr) exp_rc[j] = exp_rc[j] + 1;
        end else if (en && inr) begin
          for (int b = 0; b < 4; b++) if (we[b]) mem_m[j][idx][8*b +: 8] = wd[8*b +: 8];
          exp_wc[j] = exp_wc[j] + 1;
        end
        slot = edge_k % 8;
        exp_v[j] = ring_v[j][slot];
        if (ring_v[j][slot]) exp_d[j] = ring_d[j][slot];
        ring_v[j][slot] = 1'b0;
      end
    end
    edge_k++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    cycle(1'b0, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
    cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    for (int j = 0; j < NDut; j++) begin
      total++;
      if ({rdata_valid[j], addr_err[j], rdata[j], rd_cnt[j], wr_cnt[j]} !== 98'h0) begin
        bad++;
        $display("FAIL reset dut%0d: got v=%b e=%b d=%h rc=%0d wc=%0d want all zero",
                 j, rdata_valid[j], addr_err[j], rdata[j], rd_cnt[j], wr_cnt[j]);
      end
    end
    for (int i = 0; i < Words; i++) begin
      cycle(1'b1, 1'b1, 4'hF, 32'(4 * i), $urandom);
      cycle(1'b1, 1'b1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
    end
    idle(2);
  endtask

  task automatic test_write_read;
    cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    total++;
    if (rdata_valid[0] !== 1'b0) begin
      bad++; $display("FAIL wr_no_valid: got %b want 0", rdata_valid[0]);
    end
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    total += 2;
    if (rdata_valid[0] !== 1'b1) begin
      bad++; $display("FAIL rd_valid_l1: got %b want 1", rdata_valid[0]);
    end
    if (rdata[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL rd_data_l1: got %h want deadbeef", rdata[0]);
    end
    idle(4);
  endtask

  task automatic test_byte_lanes;
    cycle(1'b1, 1'b1, 4'hF, 32'h14, 32'h1122_3344);
    cycle(1'b1, 1'b1, 4'b0101, 32'h14, 32'hAABB_CCDD);
    cycle(1'b1, 1'b1, 4'h0, 32'h14, 32'h0);
    total++;
    if (rdata_valid[0] !== 1'b1 || rdata[0] !== 32'h11BB_33DD) begin
      bad++; $display("FAIL byte_lanes: got v=%b d=%h want v=1 d=11bb33dd", rdata_valid[0], rdata[0]);
    end
    idle(1);
    total++;
    if (rdata_valid[0] !== 1'b0 || rdata[0] !== 32'h11BB_33DD) begin
      bad++; $display("FAIL hold: got v=%b d=%h want v=0 d=11bb33dd", rdata_valid[0], rdata[0]);
    end
    idle(4);
  endtask

  task automatic test_latency3;
    logic [6:0]  pat3 = 7'b0011100;
    logic [6:0]  pat4 = 7'b0111000;
    logic [31:0] want;
    cycle(1'b1, 1'b1, 4'hF, 32'h0, 32'h0000_0100);
    cycle(1'b1, 1'b1, 4'hF, 32'h4, 32'h0000_0104);
    cycle(1'b1, 1'b1, 4'hF, 32'h8, 32'h0000_0108);
    idle(4);
    for (int e = 0; e < 7; e++) begin
      if (e < 3) cycle(1'b1, 1'b1, 4'h0, 32'(4 * e), 32'h0);
      else       idle(1);
      total += 3;
      if (rdata_valid[1] !== pat3[e]) begin
        bad++; $display("FAIL lat3_valid e%0d: got %b want %b", e, rdata_valid[1], pat3[e]);
      end
      if (rdata_valid[2] !== pat4[e]) begin
        bad++; $display("FAIL lat4_valid e%0d: got %b want %b", e, rdata_valid[2], pat4[e]);
      end
      want = (e < 2) ? exp_d[1] : 32'h100 + 32'(4 * ((e > 4) ? 2 : e - 2));
      if (rdata[1] !== want) begin
        bad++; $display("FAIL lat3_data e%0d: got %h want %h", e, rdata[1], want);
      end
    end
    idle(2);
  endtask

  task automatic test_out_of_range;
    logic [31:0] rc_before;
    logic [31:0] wc_before;
    rc_before = exp_rc[0];
    wc_before = exp_wc[0];
    cycle(1'b1, 1'b1, 4'h0, 32'h40, 32'h0);
    total++;
    if ({addr_err[0], rdata_valid[0], rdata[0], rd_cnt[0]} !== {2'b11, 32'h0, rc_before}) begin
      bad++; $display("FAIL oor_read: got e=%b v=%b d=%h rc=%0d want e=1 v=1 d=0 rc=%0d",
                      addr_err[0], rdata_valid[0], rdata[0], rd_cnt[0], rc_before);
    end
    idle(1);
    total++;
    if (addr_err[0] !== 1'b0) begin
      bad++; $display("FAIL oor_err_one_cycle: got %b want 0", addr_err[0]);
    end
    cycle(1'b1, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF);
    total += 2;
    if (addr_err[0] !== 1'b1) begin
      bad++; $display("FAIL oor_write_err: got %b want 1", addr_err[0]);
    end
    if (wr_cnt[0] !== wc_before) begin
      bad++; $display("FAIL oor_wr_cnt: got %0d want %0d", wr_cnt[0], wc_before);
    end
    cycle(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
    total++;
    if (rdata[0] !== 32'h0000_0100) begin
      bad++; $display("FAIL oor_no_change: got %h want 00000100", rdata[0]);
    end
    idle(4);
  endtask

  task automatic test_reset_inflight;
    logic seen;
    seen = 1'b0;
    cycle(1'b1, 1'b1, 4'h0, 32'h4, 32'h0);
    seen |= rdata_valid[2] | rdata_valid[1];
    idle(1);
    seen |= rdata_valid[2] | rdata_valid[1];
    cycle(1'b0, 1'b1, 4'hF, 32'h10, 32'h0BAD_F00D);
    for (int i = 0; i < 6; i++) begin
      seen |= rdata_valid[2] | rdata_valid[1];
      idle(1);
    end
    total += 2;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL inflight_killed: got valid seen=%b want 0", seen);
    end
    if (rd_cnt[2] !== 32'h0 || wr_cnt[2] !== 32'h0) begin
      bad++; $display("FAIL cnt_after_reset: got rc=%0d wc=%0d want 0 0", rd_cnt[2], wr_cnt[2]);
    end
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    total++;
    if (rdata[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL mem_kept_reset: got %h want deadbeef", rdata[0]);
    end
    idle(4);
  endtask

  task automatic test_en_low;
    cycle(1'b1, 1'b1, 4'hF, 32'h18, 32'h5A5A_5A5A);
    cycle(1'b1, 1'b0, 4'hF, 32'h18, 32'hCAFE_F00D);
    cycle(1'b1, 1'b1, 4'h0, 32'h18, 32'h0);
    total += 2;
    if (rdata[0] !== 32'h5A5A_5A5A) begin
      bad++; $display("FAIL en_low_mem: got %h want 5a5a5a5a", rdata[0]);
    end
    if (wr_cnt[0] !== 32'd1) begin
      bad++; $display("FAIL en_low_wr_cnt: got %0d want 1", wr_cnt[0]);
    end
    idle(4);
  endtask

  task automatic test_random;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 63) != 0);
      en   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h17F));
      cycle(rst, en, we, addr, $urandom);
      for (int j = 0; j < NDut; j++) begin
        total += 5;
        if (rdata_valid[j] !== exp_v[j]) begin
          bad++; $display("FAIL rand_valid dut%0d c%0d: got %b want %b", j, c, rdata_valid[j], exp_v[j]);
        end
        if (rdata[j] !== exp_d[j]) begin
          bad++; $display("FAIL rand_data dut%0d c%0d: got %h want %h", j, c, rdata[j], exp_d[j]);
        end
        if (addr_err[j] !== exp_err[j]) begin
          bad++; $display("FAIL rand_err dut%0d c%0d: got %b want %b", j, c, addr_err[j], exp_err[j]);
        end
        if (rd_cnt[j] !== exp_rc[j]) begin
          bad++; $display("FAIL rand_rd_cnt dut%0d c%0d: got %0d want %0d", j, c, rd_cnt[j], exp_rc[j]);
        end
        if (wr_cnt[j] !== exp_wc[j]) begin
          bad++; $display("FAIL rand_wr_cnt dut%0d c%0d: got %0d want %0d", j, c, wr_cnt[j], exp_wc[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_latency3();
    test_out_of_range();
    test_reset_inflight();
    test_en_low();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
